// File: rtl/com_pkg.sv
// Shared definitions for the command sequencer and its serializer stage:
// FSM state encoding and default block parameters.
package com_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_NUM_CMDS = 10;
    localparam int DEF_CLK_DIV  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_END   = 3'd4
    } com_state_e;

endpackage

// File: rtl/com_clk_div.sv
// Serial clock divider: tick every CLK_DIV cycles while enabled; phase says
// whether the coming tick is a rising (0) or falling (1) sclk edge.
module com_clk_div
    import com_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick,
    output logic phase
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_MAX);

    // Divider counter and phase toggle, both cleared whenever disabled.
    always_ff @(posedge clk) begin
        if (!reset || !en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/com_serializer.sv
// Command serializer: on each Write fetches the next ROM word and shifts it
// MSB-first over cs_n/sclk/sdata, then reports NewCom or ComEnd.
module com_serializer
    import com_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_CMDS = DEF_NUM_CMDS,
    parameter int CLK_DIV  = DEF_CLK_DIV
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Write,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              cs_n,
    output logic              sclk,
    output logic              sdata,
    output logic              NewCom,
    output logic              ComEnd,
    output logic              busy
);

    localparam int BCNT_W = $clog2(DATA_W + 1);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);
    localparam logic [ADDR_W:0]   NUM_CMDS_V = (ADDR_W + 1)'(NUM_CMDS);

    com_state_e        state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shifted;
    logic [BCNT_W-1:0] bit_cnt;
    logic              div_en;
    logic              tick;
    logic              phase;
    logic              more_cmds;

    assign cmd_addr  = ptr;
    assign shifted   = shreg << 1;
    assign div_en    = (state == ST_SHIFT);
    // Compared one bit wider so NUM_CMDS == 2^ADDR_W is representable.
    assign more_cmds = (({1'b0, ptr} + {{ADDR_W{1'b0}}, 1'b1}) < NUM_CMDS_V);

    com_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk   (clk),
        .reset (reset),
        .en    (div_en),
        .tick  (tick),
        .phase (phase)
    );

    // Serializer FSM with shift register, bit counter, pointer and outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
            cs_n    <= 1'b1;
            sclk    <= 1'b0;
            sdata   <= 1'b0;
            NewCom  <= 1'b0;
            ComEnd  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            NewCom <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Write) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    shreg   <= cmd_data;
                    bit_cnt <= '0;
                    cs_n    <= 1'b0;
                    sdata   <= cmd_data[DATA_W-1];
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (tick) begin
                        sclk <= ~phase;
                        if (phase) begin
                            shreg   <= shifted;
                            sdata   <= shifted[DATA_W-1];
                            bit_cnt <= bit_cnt + BCNT_W'(1);
                            if (bit_cnt == LAST_BIT) begin
                                cs_n  <= 1'b1;
                                sdata <= 1'b0;
                                busy  <= 1'b0;
                                if (!(&ptr)) begin
                                    ptr <= ptr + ADDR_W'(1);
                                end
                                if (more_cmds) begin
                                    state  <= ST_DONE;
                                    NewCom <= 1'b1;
                                end else begin
                                    state  <= ST_END;
                                    ComEnd <= 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (Write) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_END: begin
                    ComEnd <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_com_serializer.sv
// Self-checking bench for com_serializer: default-parameter instance plus a
// CLK_DIV=1 / NUM_CMDS=1 instance, each fed by a synchronous ROM model.
module tb_com_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: default parameters.
    logic        reset0, wr_pulse0, tie0, write0;
    logic [3:0]  addr0;
    logic [15:0] data0;
    logic        cs0, sclk0, sd0, nc0, ce0, busy0;
    assign write0 = wr_pulse0 | (tie0 & nc0);

    // Instance 1: fastest divider, single table entry.
    logic        reset1, wr_pulse1;
    logic [3:0]  addr1;
    logic [15:0] data1;
    logic        cs1, sclk1, sd1, nc1, ce1, busy1;

    com_serializer #(.DATA_W(16), .ADDR_W(4), .NUM_CMDS(10), .CLK_DIV(4)) dut0 (
        .clk(clk), .reset(reset0), .Write(write0), .cmd_addr(addr0), .cmd_data(data0),
        .cs_n(cs0), .sclk(sclk0), .sdata(sd0), .NewCom(nc0), .ComEnd(ce0), .busy(busy0)
    );

    com_serializer #(.DATA_W(16), .ADDR_W(4), .NUM_CMDS(1), .CLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset1), .Write(wr_pulse1), .cmd_addr(addr1), .cmd_data(data1),
        .cs_n(cs1), .sclk(sclk1), .sdata(sd1), .NewCom(nc1), .ComEnd(ce1), .busy(busy1)
    );

    logic [15:0] rom0 [0:15];
    logic [15:0] rom1 [0:15];

    always @(posedge clk) begin
        data0 <= rom0[addr0];
        data1 <= rom1[addr1];
    end

    typedef struct packed {
        logic       cs_n;
        logic       sclk;
        logic       sdata;
        logic       nc;
        logic       ce;
        logic       busy;
        logic [3:0] addr;
    } obs_t;

    typedef struct {
        int   sel;
        int   cyc;
        obs_t exp;
    } vec_t;

    obs_t obs0, obs1;
    assign obs0 = {cs0, sclk0, sd0, nc0, ce0, busy0, addr0};
    assign obs1 = {cs1, sclk1, sd1, nc1, ce1, busy1, addr1};

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    localparam obs_t RST_OBS = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

    function automatic vec_t mk(int sel, int cyc, logic cs_n, logic sc, logic sd,
                                logic nc, logic ce, logic bsy, logic [3:0] addr);
        vec_t v;
        v.sel = sel;
        v.cyc = cyc;
        v.exp = {cs_n, sc, sd, nc, ce, bsy, addr};
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic obs_t get_obs(int sel);
        return (sel == 0) ? obs0 : obs1;
    endfunction

    task automatic set_write(int sel, logic v);
        if (sel == 0) wr_pulse0 = v;
        else          wr_pulse1 = v;
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset0();
        reset0 = 1'b0;
        tick_cycle();
        check("reset0_state", get_obs(0), RST_OBS);
        reset0 = 1'b1;
        tick_cycle();
    endtask

    // Single Write from IDLE; cycle 1 is the LOAD cycle.
    task automatic run_frame(int sel, int ncyc, logic [15:0] exp_word, int exp_nc);
        logic [15:0] word;
        int          rises, ncs;
        logic        prev_sclk;
        obs_t        o;
        word = 16'h0000; rises = 0; ncs = 0; prev_sclk = 1'b0;
        set_write(sel, 1'b1);
        tick_cycle();
        set_write(sel, 1'b0);
        for (int c = 1; c <= ncyc; c++) begin
            if (c > 1) tick_cycle();
            o = get_obs(sel);
            foreach (vecs[i]) begin
                if (vecs[i].sel == sel && vecs[i].cyc == c)
                    check($sformatf("dut%0d_cyc%0d", sel, c), o, vecs[i].exp);
            end
            if (o.sclk && !prev_sclk) begin
                word = {word[14:0], o.sdata};
                rises++;
            end
            if (o.nc) ncs++;
            prev_sclk = o.sclk;
        end
        check($sformatf("dut%0d_word", sel), word, exp_word);
        check($sformatf("dut%0d_rises", sel), rises, 16);
        check($sformatf("dut%0d_newcom_cnt", sel), ncs, exp_nc);
    endtask

    initial begin
        int          frames, ncs, gap, bits, after, cs_falls;
        logic [15:0] word;
        logic        prev_cs, prev_sclk, seen_end, rst_done;

        for (int i = 0; i < 16; i++) begin
            rom0[i] = 16'h1357 + 16'(i) * 16'h0F1D;
            rom1[i] = 16'h0000;
        end
        rom0[0] = 16'hA5C3;
        rom1[0] = 16'h3C5A;

        // Instance 0, A5C3 = 1010_0101_1100_0011, CLK_DIV=4.
        vecs.push_back(mk(0,   1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0));
        vecs.push_back(mk(0,   2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0));
        vecs.push_back(mk(0,   5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0));
        vecs.push_back(mk(0,   6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0));
        vecs.push_back(mk(0,  10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0));
        vecs.push_back(mk(0,  18, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0));
        vecs.push_back(mk(0,  66, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0));
        vecs.push_back(mk(0,  82, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0));
        vecs.push_back(mk(0, 122, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0));
        vecs.push_back(mk(0, 129, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0));
        vecs.push_back(mk(0, 130, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1));
        vecs.push_back(mk(0, 131, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1));
        // Instance 1, 3C5A = 0011_1100_0101_1010, CLK_DIV=1, NUM_CMDS=1.
        vecs.push_back(mk(1,   1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0));
        vecs.push_back(mk(1,   2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0));
        vecs.push_back(mk(1,   3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0));
        vecs.push_back(mk(1,   6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0));
        vecs.push_back(mk(1,  33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0));
        vecs.push_back(mk(1,  34, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1));
        vecs.push_back(mk(1,  35, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1));

        reset0 = 1'b0; reset1 = 1'b0;
        wr_pulse0 = 1'b0; wr_pulse1 = 1'b0; tie0 = 1'b0;
        repeat (3) tick_cycle();
        check("reset_dut0", obs0, RST_OBS);
        check("reset_dut1", obs1, RST_OBS);
        reset0 = 1'b1; reset1 = 1'b1;
        tick_cycle();
        check("idle_dut0", obs0, RST_OBS);

        // Single frame on each instance.
        run_frame(0, 131, 16'hA5C3, 1);
        run_frame(1, 35, 16'h3C5A, 0);

        // Instance 1 in END: Write held high must not start a frame.
        wr_pulse1 = 1'b1;
        cs_falls = 0;
        for (int c = 0; c < 20; c++) begin
            tick_cycle();
            if (!cs1) cs_falls++;
        end
        wr_pulse1 = 1'b0;
        check("end1_no_frame", cs_falls, 0);
        check("end1_state", obs1, {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1});

        // Sequencer-style back-to-back run through all ten entries.
        pulse_reset0();
        tie0 = 1'b1;
        frames = 0; ncs = 0; gap = 0; bits = 0; after = 0;
        word = 16'h0000; prev_cs = 1'b1; prev_sclk = 1'b0; seen_end = 1'b0;
        wr_pulse0 = 1'b1;
        tick_cycle();
        wr_pulse0 = 1'b0;
        for (int c = 1; c <= 1500 && after < 5; c++) begin
            if (c > 1) tick_cycle();
            if (prev_cs && !cs0) begin
                if (frames > 0) check($sformatf("gap_before_f%0d", frames), gap, 2);
                bits = 0; word = 16'h0000;
            end
            if (!prev_cs && cs0) begin
                check($sformatf("b2b_word_f%0d", frames), word, rom0[frames]);
                check($sformatf("b2b_bits_f%0d", frames), bits, 16);
                check($sformatf("b2b_newcom_f%0d", frames), nc0, (frames < 9) ? 1 : 0);
                check($sformatf("b2b_comend_f%0d", frames), ce0, (frames < 9) ? 0 : 1);
                frames++;
                gap = 0;
            end
            if (cs0) gap++;
            if (sclk0 && !prev_sclk) begin
                word = {word[14:0], sd0};
                bits++;
            end
            if (nc0) ncs++;
            if (seen_end) begin
                check("comend_hold", ce0, 1);
                after++;
            end
            if (ce0) seen_end = 1'b1;
            prev_cs = cs0; prev_sclk = sclk0;
        end
        check("b2b_frames", frames, 10);
        check("b2b_newcom_cnt", ncs, 9);
        check("b2b_ptr", addr0, 10);

        // Write held high while in END.
        wr_pulse0 = 1'b1;
        cs_falls = 0;
        for (int c = 0; c < 300; c++) begin
            tick_cycle();
            if (!cs0) cs_falls++;
        end
        wr_pulse0 = 1'b0; tie0 = 1'b0;
        check("end0_no_frame", cs_falls, 0);
        check("end0_state", obs0, {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd10});

        // Write held high through LOAD and SHIFT, released in DONE.
        pulse_reset0();
        wr_pulse0 = 1'b1;
        cs_falls = 0; prev_cs = 1'b1;
        for (int c = 1; c <= 129; c++) begin
            tick_cycle();
            if (prev_cs && !cs0) cs_falls++;
            prev_cs = cs0;
        end
        tick_cycle();
        wr_pulse0 = 1'b0;
        check("held_done_newcom", nc0, 1);
        for (int c = 0; c < 10; c++) begin
            tick_cycle();
            if (!cs0) cs_falls++;
        end
        check("held_one_frame", cs_falls, 1);
        check("held_ptr", addr0, 1);

        // Reset in the middle of frame 3.
        pulse_reset0();
        tie0 = 1'b1;
        frames = 0; bits = 0; prev_cs = 1'b1; prev_sclk = 1'b0; rst_done = 1'b0;
        wr_pulse0 = 1'b1;
        tick_cycle();
        wr_pulse0 = 1'b0;
        for (int c = 1; c <= 600 && !rst_done; c++) begin
            if (c > 1) tick_cycle();
            if (prev_cs && !cs0) bits = 0;
            if (!prev_cs && cs0) frames++;
            if (sclk0 && !prev_sclk) bits++;
            prev_cs = cs0; prev_sclk = sclk0;
            if (frames == 2 && !cs0 && bits == 7) begin
                reset0 = 1'b0;
                tick_cycle();
                check("midreset_state", obs0, RST_OBS);
                rst_done = 1'b1;
            end
        end
        check("midreset_reached", rst_done, 1);
        reset0 = 1'b1; tie0 = 1'b0;
        tick_cycle();
        run_frame(0, 131, 16'hA5C3, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
